// File: rtl/video_stream_aligner_pkg.sv
// Shared types and helpers for the camera/SD-card frame aligner.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package video_stream_aligner_pkg;

    localparam int DATA_W_DEF = 16;   // RGB565 pixel
    localparam int CNT_W_DEF  = 17;   // holds 320*240 with headroom
    localparam int RESYNC_W   = 8;

    // Top-level alignment state: hunting for a common sop, or pairing beats.
    typedef enum logic {
        ST_SEEK = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // What the two stream heads look like relative to each other on a pairing cycle.
    typedef enum logic [1:0] {
        HC_PAIR     = 2'd0,   // framing agrees: ordinary paired beat
        HC_EOP_SKEW = 2'd1,   // framing lost with both heads still in the same frame
        HC_SOP_SKEW = 2'd2    // one stream already started a new frame
    } head_class_e;

    // Exactly-one-sop outranks an eop mismatch because the sop head must be
    // kept for the relock; a frame whose first beat has no sop on either side
    // is just as broken as an eop mismatch.
    function automatic head_class_e classify_heads(
        input logic cam_sop,
        input logic cam_eop,
        input logic sd_sop,
        input logic sd_eop,
        input logic first_beat
    );
        head_class_e cls;
        cls = HC_PAIR;
        if (cam_sop != sd_sop) begin
            cls = HC_SOP_SKEW;
        end else if (first_beat && !cam_sop) begin
            cls = HC_EOP_SKEW;
        end else if (cam_eop != sd_eop) begin
            cls = HC_EOP_SKEW;
        end
        return cls;
    endfunction

    function automatic logic [RESYNC_W-1:0] sat_inc_resync(input logic [RESYNC_W-1:0] v);
        return (&v) ? v : v + {{(RESYNC_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/video_stream_aligner_out_reg.sv
// One-entry registered valid/ready source stage carrying the paired beat payload.
// Latency: 1 cycle from load_i to valid_o/payload_o.
// Backpressure: accepts a new load only when empty or the held beat is taken this cycle; holds otherwise.
module video_stream_aligner_out_reg #(
    parameter int PAYLOAD_W = 34
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_i,
    input  logic [PAYLOAD_W-1:0] payload_i,
    input  logic                 ready_i,
    output logic                 can_load_o,
    output logic                 valid_o,
    output logic [PAYLOAD_W-1:0] payload_o
);

    logic                 valid_q;
    logic                 valid_d;
    logic [PAYLOAD_W-1:0] payload_q;
    logic [PAYLOAD_W-1:0] payload_d;

    assign can_load_o = ~valid_q | ready_i;

    // Next-state: refill (or empty) only when the slot is free this cycle.
    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        if (can_load_o) begin
            valid_d = load_i;
            if (load_i) begin
                payload_d = payload_i;
            end
        end
    end

    // Register stage; reset discards whatever beat was held.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
        end
    end

    assign valid_o   = valid_q;
    assign payload_o = payload_q;

endmodule

// File: rtl/video_stream_aligner.sv
// Locks camera and SD-card video streams to a common frame boundary and emits paired beats.
// Latency: 1 cycle from both input heads to the registered source outputs.
// Backpressure: both sinks stall while the output register is full and not being drained.
module video_stream_aligner
    import video_stream_aligner_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                camera_valid_in,
    output logic                camera_ready_out,
    input  logic [DATA_W-1:0]   camera_data_in,
    input  logic                camera_startofpacket_in,
    input  logic                camera_endofpacket_in,
    input  logic                sdcard_valid_in,
    output logic                sdcard_ready_out,
    input  logic [DATA_W-1:0]   sdcard_data_in,
    input  logic                sdcard_startofpacket_in,
    input  logic                sdcard_endofpacket_in,
    output logic                source_valid_out,
    input  logic                source_ready_in,
    output logic [DATA_W-1:0]   source_camera_data_out,
    output logic [DATA_W-1:0]   source_sdcard_data_out,
    output logic                source_startofpacket_out,
    output logic                source_endofpacket_out,
    output logic                locked,
    output logic [RESYNC_W-1:0] resync_count,
    output logic [CNT_W-1:0]    last_frame_len
);

    localparam int PAYLOAD_W = 2 * DATA_W + 2;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e                state_q;
    state_e                state_d;
    logic                  locked_q;
    logic [CNT_W-1:0]      beat_cnt_q;
    logic [CNT_W-1:0]      beat_cnt_d;
    logic [CNT_W-1:0]      beat_cnt_inc;
    logic [CNT_W-1:0]      last_len_q;
    logic [CNT_W-1:0]      last_len_d;
    logic [RESYNC_W-1:0]   resync_q;
    logic [RESYNC_W-1:0]   resync_d;

    logic                  can_load;
    logic                  cam_at_sop;
    logic                  sd_at_sop;
    logic                  seek_lock;
    logic                  first_beat;
    logic                  fire;
    logic                  resync_evt;
    logic                  out_sop;
    logic                  out_eop;
    head_class_e           head_class;
    logic [PAYLOAD_W-1:0]  pair_payload;
    logic [PAYLOAD_W-1:0]  src_payload;

    assign cam_at_sop = camera_valid_in & camera_startofpacket_in;
    assign sd_at_sop  = sdcard_valid_in & sdcard_startofpacket_in;
    assign seek_lock  = cam_at_sop & sd_at_sop;

    // The counter is cleared at every frame end and on relock, so zero marks the first beat.
    assign first_beat   = (beat_cnt_q == '0);
    assign beat_cnt_inc = (&beat_cnt_q) ? beat_cnt_q : beat_cnt_q + CNT_ONE;

    assign fire = (state_q == ST_RUN) & camera_valid_in & sdcard_valid_in & can_load;

    assign head_class = classify_heads(camera_startofpacket_in, camera_endofpacket_in,
                                       sdcard_startofpacket_in, sdcard_endofpacket_in,
                                       first_beat);
    assign resync_evt = (head_class != HC_PAIR);

    // A resync beat always closes the frame so downstream never sees an open packet.
    assign out_sop = camera_startofpacket_in & sdcard_startofpacket_in;
    assign out_eop = camera_endofpacket_in | sdcard_endofpacket_in | resync_evt;

    assign pair_payload = {out_sop, out_eop, camera_data_in, sdcard_data_in};

    // Sink handshakes: in SEEK drop until each head sits on sop; in RUN consume
    // only on a firing cycle, keeping a lone sop head for the next relock.
    always_comb begin
        camera_ready_out = 1'b0;
        sdcard_ready_out = 1'b0;
        if (state_q == ST_SEEK) begin
            camera_ready_out = ~cam_at_sop;
            sdcard_ready_out = ~sd_at_sop;
        end else if (fire) begin
            camera_ready_out = ~((head_class == HC_SOP_SKEW) & camera_startofpacket_in);
            sdcard_ready_out = ~((head_class == HC_SOP_SKEW) & sdcard_startofpacket_in);
        end
    end

    // FSM and counter next-state: frame length captured on every closing beat.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        last_len_d = last_len_q;
        resync_d   = resync_q;
        case (state_q)
            ST_SEEK: begin
                if (seek_lock) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (fire) begin
                    if (out_eop) begin
                        last_len_d = beat_cnt_inc;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_inc;
                    end
                    if (resync_evt) begin
                        state_d  = ST_SEEK;
                        resync_d = sat_inc_resync(resync_q);
                    end
                end
            end
            default: state_d = ST_SEEK;
        endcase
    end

    // State, counters and the registered lock flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_SEEK;
            locked_q   <= 1'b0;
            beat_cnt_q <= '0;
            last_len_q <= '0;
            resync_q   <= '0;
        end else begin
            state_q    <= state_d;
            locked_q   <= (state_d == ST_RUN);
            beat_cnt_q <= beat_cnt_d;
            last_len_q <= last_len_d;
            resync_q   <= resync_d;
        end
    end

    video_stream_aligner_out_reg #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_out_reg (
        .clk        (clk),
        .reset      (reset),
        .load_i     (fire),
        .payload_i  (pair_payload),
        .ready_i    (source_ready_in),
        .can_load_o (can_load),
        .valid_o    (source_valid_out),
        .payload_o  (src_payload)
    );

    assign source_startofpacket_out = src_payload[PAYLOAD_W-1];
    assign source_endofpacket_out   = src_payload[PAYLOAD_W-2];
    assign source_camera_data_out   = src_payload[2*DATA_W-1:DATA_W];
    assign source_sdcard_data_out   = src_payload[DATA_W-1:0];

    assign locked         = locked_q;
    assign resync_count   = resync_q;
    assign last_frame_len = last_len_q;

endmodule
